// File: rtl/seq_det_arbiter.sv
// seq_det_arbiter: round-robin sharing of one serial pattern comparator
// across N_CH requester channels, each with its own shift-history context.
// Owns the target pattern, flushes channel contexts after every target
// load, and keeps a saturating global match counter.
//
// Optional build macro: SEQ_DET_NONOVERLAP_EN
//   defined   - a matching transfer also clears that channel's fill count,
//               so overlapping matches are suppressed
//   undefined - overlapping matches are reported
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | configurable (cfg_ready=1), no grants; waits for cfg_we/en
// ST_RUN   | arbitrating channels, shifting bits, comparing to target
// ST_FLUSH | clearing one channel context per cycle after a target load
module seq_det_arbiter #(
   parameter int               N_CH           = 4,
   parameter int               PAT_W          = 4,
   parameter logic [PAT_W-1:0] TARGET_DEFAULT = 4'b1101,
   parameter int               CNT_W          = 16,
   parameter int               ID_W           = $clog2(N_CH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [N_CH-1:0]   in_valid,
   input  logic [N_CH-1:0]   in_data,
   output logic [N_CH-1:0]   in_ready,
   input  logic              cfg_we,
   input  logic [PAT_W-1:0]  cfg_target,
   output logic              cfg_ready,
   input  logic              cnt_clr,
   output logic              match,
   output logic [ID_W-1:0]   match_id,
   output logic [CNT_W-1:0]  match_cnt
);

   localparam int FILL_W = $clog2(PAT_W + 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [PAT_W-1:0]   target_q, target_d;
   logic [PAT_W-1:0]   hist_q [N_CH];
   logic [PAT_W-1:0]   hist_d [N_CH];
   logic [FILL_W-1:0]  fill_q [N_CH];
   logic [FILL_W-1:0]  fill_d [N_CH];
   logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0]    flush_ptr_q, flush_ptr_d;
   logic               match_q, match_d;
   logic [ID_W-1:0]    match_id_q, match_id_d;
   logic [CNT_W-1:0]   match_cnt_q, match_cnt_d;

   logic [N_CH-1:0]    grant;
   logic               gnt_found;
   logic [ID_W-1:0]    gnt_idx;
   logic [ID_W-1:0]    cand;
   logic [PAT_W-1:0]   new_hist;
   logic               hit;

   // Round-robin search starting just after the last granted channel
   always_comb begin
      grant     = '0;
      gnt_found = 1'b0;
      gnt_idx   = rr_ptr_q;
      cand      = rr_ptr_q;
      if (state_q == ST_RUN && en) begin
         for (int k = 1; k <= N_CH; k++) begin
            cand = ID_W'((int'(rr_ptr_q) + k) % N_CH);
            if (!gnt_found && in_valid[cand]) begin
               gnt_found = 1'b1;
               gnt_idx   = cand;
            end
         end
      end
      if (gnt_found) begin
         grant[gnt_idx] = 1'b1;
      end
   end

   // Next-state logic: FSM, channel contexts, match pulse and counter
   always_comb begin
      state_d     = state_q;
      target_d    = target_q;
      hist_d      = hist_q;
      fill_d      = fill_q;
      rr_ptr_d    = rr_ptr_q;
      flush_ptr_d = flush_ptr_q;
      match_d     = 1'b0;
      match_id_d  = match_id_q;
      match_cnt_d = match_cnt_q;
      new_hist    = {hist_q[gnt_idx][PAT_W-2:0], in_data[gnt_idx]};
      hit         = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (cfg_we) begin
               target_d    = cfg_target;
               flush_ptr_d = '0;
               state_d     = ST_FLUSH;
            end else if (en) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (!en) begin
               state_d = ST_IDLE;
            end else if (gnt_found) begin
               rr_ptr_d        = gnt_idx;
               hist_d[gnt_idx] = new_hist;
               // fill is checked before this transfer: PAT_W-1 old bits plus
               // the new one make a complete window
               hit = (new_hist == target_q) &&
                     (fill_q[gnt_idx] >= FILL_W'(PAT_W - 1));
               if (fill_q[gnt_idx] < FILL_W'(PAT_W)) begin
                  fill_d[gnt_idx] = fill_q[gnt_idx] + 1'b1;
               end
`ifdef SEQ_DET_NONOVERLAP_EN
               if (hit) begin
                  fill_d[gnt_idx] = '0;
               end
`endif
               match_d = hit;
               if (hit) begin
                  match_id_d = gnt_idx;
               end
            end
         end
         ST_FLUSH: begin
            hist_d[flush_ptr_q] = '0;
            fill_d[flush_ptr_q] = '0;
            if (flush_ptr_q == ID_W'(N_CH - 1)) begin
               state_d = ST_IDLE;
            end else begin
               flush_ptr_d = flush_ptr_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // A clear in the same cycle as a matching transfer drops that match
      if (cnt_clr) begin
         match_cnt_d = '0;
      end else if (match_d && (match_cnt_q != '1)) begin
         match_cnt_d = match_cnt_q + 1'b1;
      end
   end

   // State registers with asynchronous active-low reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         target_q    <= TARGET_DEFAULT;
         for (int i = 0; i < N_CH; i++) begin
            hist_q[i] <= '0;
            fill_q[i] <= '0;
         end
         rr_ptr_q    <= ID_W'(N_CH - 1);
         flush_ptr_q <= '0;
         match_q     <= 1'b0;
         match_id_q  <= '0;
         match_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         target_q    <= target_d;
         for (int i = 0; i < N_CH; i++) begin
            hist_q[i] <= hist_d[i];
            fill_q[i] <= fill_d[i];
         end
         rr_ptr_q    <= rr_ptr_d;
         flush_ptr_q <= flush_ptr_d;
         match_q     <= match_d;
         match_id_q  <= match_id_d;
         match_cnt_q <= match_cnt_d;
      end
   end

   assign in_ready  = grant;
   assign cfg_ready = (state_q == ST_IDLE);
   assign match     = match_q;
   assign match_id  = match_id_q;
   assign match_cnt = match_cnt_q;

endmodule
